// File: rtl/johnson_pkg.sv
// Shared definitions for Johnson-code consumers: FSM encoding, code table and index width.
package johnson_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } jstate_t;

  // Width of a binary phase index for a W-bit Johnson code (2*W phases).
  function automatic int johnson_idx_w(input int w);
    return (2 * w > 1) ? $clog2(2 * w) : 1;
  endfunction

  // J(k): k ones filling from the LSB, then zeros filling from the LSB.
  function automatic logic [31:0] johnson_code(input int k, input int w);
    logic [31:0] full;
    full = (32'd1 << w) - 32'd1;
    if (k <= w) begin
      return (32'd1 << k) - 32'd1;
    end
    return full & ~((32'd1 << (k - w)) - 32'd1);
  endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational Johnson code to {legal, phase index} decoder.
module johnson_code_decode
  import johnson_pkg::*;
#(
  parameter int W  = 4,
  parameter int IW = johnson_idx_w(W)
) (
  input  logic [W-1:0]  code_i,
  output logic          legal_o,
  output logic [IW-1:0] index_o
);

  always_comb begin
    legal_o = 1'b0;
    index_o = '0;
    for (int k = 0; k < 2 * W; k++) begin
      if ({{(32 - W){1'b0}}, code_i} == johnson_code(k, W)) begin
        legal_o = 1'b1;
        index_o = IW'(k);
      end
    end
  end

endmodule

// File: rtl/johnson_rx_checker.sv
// Johnson-code receive checker: input register stage, decode, lock FSM and saturating error count.
// Optional terminal-count check is built when JOHNSON_TC_CHECK_EN is defined.
//
// state  | meaning
// HUNT   | searching for LOCK_CNT consecutive correct advances
// LOCKED | sequence tracked; any deviation raises err and drops to HUNT
module johnson_rx_checker
  import johnson_pkg::*;
#(
  parameter int W        = 4,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic                        clk,
  input  logic                        clr_n,
  input  logic                        ce_in,
  input  logic [W-1:0]                code_in,
  input  logic                        tc_in,
  output logic [johnson_idx_w(W)-1:0] idx,
  output logic                        idx_vld,
  output logic                        locked,
  output logic                        err,
  output logic [ERR_W-1:0]            err_cnt
);

  localparam int IW = johnson_idx_w(W);
  localparam int N  = 2 * W;

  logic          ce_q;
  logic [W-1:0]  code_q;

  jstate_t       state_q, state_d;
  logic [IW-1:0] exp_q, exp_d;
  logic [3:0]    run_q, run_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          vld_q, vld_d;
  logic          err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic          legal;
  logic [IW-1:0] dec_idx;
  logic [IW-1:0] exp_nxt;

`ifdef JOHNSON_TC_CHECK_EN
  localparam logic [31:0] J_LAST = johnson_code(N - 1, W);
  logic tc_q;
  logic tc_mis;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      tc_q <= 1'b0;
    end else begin
      tc_q <= tc_in;
    end
  end

  assign tc_mis = (tc_q != ({{(32 - W){1'b0}}, code_q} == J_LAST));
`else
  logic unused_tc;
  assign unused_tc = tc_in;
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ce_q   <= 1'b0;
      code_q <= '0;
    end else begin
      ce_q   <= ce_in;
      code_q <= code_in;
    end
  end

  johnson_code_decode #(.W(W), .IW(IW)) u_decode (
    .code_i  (code_q),
    .legal_o (legal),
    .index_o (dec_idx)
  );

  assign exp_nxt = (exp_q == IW'(N - 1)) ? '0 : exp_q + IW'(1);

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    run_d     = run_q;
    err_d     = 1'b0;
    idx_d     = legal ? dec_idx : idx_q;
    vld_d     = legal;
    err_cnt_d = err_cnt_q;

    case (state_q)
      HUNT: begin
        if (!legal) begin
          err_d = 1'b1;
          run_d = '0;
        end else if (run_q == '0) begin
          exp_d = dec_idx;
          run_d = 4'd1;
        end else if (ce_q) begin
          if (dec_idx == exp_nxt) begin
            exp_d = exp_nxt;
            run_d = run_q + 4'd1;
            // run counts samples, so run_q advances have already been seen
            if (run_q >= 4'(LOCK_CNT)) begin
              state_d = LOCKED;
            end
          end else begin
            exp_d = dec_idx;
            run_d = 4'd1;
          end
        end else if (dec_idx != exp_q) begin
          exp_d = dec_idx;
          run_d = 4'd1;
        end
      end
      LOCKED: begin
        if (!legal || (ce_q && dec_idx != exp_nxt) || (!ce_q && dec_idx != exp_q)) begin
          err_d   = 1'b1;
          state_d = HUNT;
          run_d   = '0;
        end else if (ce_q) begin
          exp_d = exp_nxt;
        end
`ifdef JOHNSON_TC_CHECK_EN
        if (tc_mis) begin
          err_d = 1'b1;
        end
`endif
      end
      default: begin
        state_d = HUNT;
        run_d   = '0;
      end
    endcase

    if (err_d && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= HUNT;
      exp_q     <= '0;
      run_q     <= '0;
      idx_q     <= '0;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      run_q     <= run_d;
      idx_q     <= idx_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign idx     = idx_q;
  assign idx_vld = vld_q;
  assign locked  = (state_q == LOCKED);
  assign err     = err_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_johnson_rx_checker.sv
// Scoreboard bench for johnson_rx_checker (W=4, LOCK_CNT=2, ERR_W=8).
module tb_johnson_rx_checker;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       ce_in = 1'b0;
  logic [3:0] code_in = 4'b0000;
  logic       tc_in = 1'b0;
  logic [2:0] idx;
  logic       idx_vld;
  logic       locked;
  logic       err;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] m_cnt = 8'd0;

`ifdef JOHNSON_TC_CHECK_EN
  localparam logic TC_EN = 1'b1;
`else
  localparam logic TC_EN = 1'b0;
`endif

  typedef struct {
    int         due;
    logic [2:0] idx;
    logic       vld;
    logic       lock;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  logic [3:0] jt[8];

  johnson_rx_checker #(.W(4), .LOCK_CNT(2), .ERR_W(8)) dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .ce_in   (ce_in),
    .code_in (code_in),
    .tc_in   (tc_in),
    .idx     (idx),
    .idx_vld (idx_vld),
    .locked  (locked),
    .err     (err),
    .err_cnt (err_cnt)
  );

  always #10 clk = ~clk;

  // Monitor: outputs for the sample driven before posedge c appear after posedge c+1.
  always @(posedge clk) begin
    cyc++;
    #1;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (e.due != cyc || idx !== e.idx || idx_vld !== e.vld || locked !== e.lock ||
          err !== e.err || err_cnt !== e.cnt) begin
        errors++;
        $display("FAIL sb due=%0d cyc=%0d idx/vld/lock/err/cnt got %0d/%0b/%0b/%0b/%0d want %0d/%0b/%0b/%0b/%0d",
                 e.due, cyc, idx, idx_vld, locked, err, err_cnt,
                 e.idx, e.vld, e.lock, e.err, e.cnt);
      end
    end
  end

  task automatic step(input logic ce, input logic [3:0] code, input logic tc_flip,
                      input logic [2:0] e_idx, input logic e_vld, input logic e_lock,
                      input logic e_err);
    exp_t e;
    @(negedge clk);
    ce_in   = ce;
    code_in = code;
    tc_in   = (code == 4'b1000) ^ tc_flip;
    if (e_err && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    e.due  = cyc + 2;
    e.idx  = e_idx;
    e.vld  = e_vld;
    e.lock = e_lock;
    e.err  = e_err;
    e.cnt  = m_cnt;
    sb.push_back(e);
  endtask

  task automatic chk_zero(input string tag);
    checks++;
    if ({idx, idx_vld, locked, err, err_cnt} !== 14'd0) begin
      errors++;
      $display("FAIL %s idx/vld/lock/err/cnt got %0d/%0b/%0b/%0b/%0d want all 0",
               tag, idx, idx_vld, locked, err, err_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    jt = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};

    repeat (2) @(negedge clk);
    chk_zero("reset_hold");
    @(negedge clk);
    clr_n = 1'b1;

    // Free-running stream from 0000: lock on the 3rd legal sample, wrap 7->0.
    for (int k = 0; k < 11; k++) begin
      step(1'b1, jt[k % 8], 1'b0, 3'(k % 8), 1'b1, (k >= 2), 1'b0);
    end

    // ce toggling every two clocks: held code accepted while ce is low.
    for (int k = 3; k < 9; k++) begin
      step(1'b1, jt[k % 8], 1'b0, 3'(k % 8), 1'b1, 1'b1, 1'b0);
      step(1'b0, jt[k % 8], 1'b0, 3'(k % 8), 1'b1, 1'b1, 1'b0);
    end
    step(1'b1, 4'b0001, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 4'b0011, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0);

    // Skip from 0011 to 1111: error, HUNT, reseed at 4, relock.
    step(1'b1, 4'b1111, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1);
    step(1'b0, 4'b1111, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'b1110, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'b1100, 1'b0, 3'd6, 1'b1, 1'b1, 1'b0);
    step(1'b1, 4'b1000, 1'b0, 3'd7, 1'b1, 1'b1, 1'b0);
    step(1'b1, 4'b0000, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 4'b0001, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 4'b0011, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0);

    // Illegal 0101 while locked: idx held, vld low, relock after two advances.
    step(1'b1, 4'b0101, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'b0111, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'b1111, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'b1110, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0);
    step(1'b1, 4'b1100, 1'b0, 3'd6, 1'b1, 1'b1, 1'b0);
    step(1'b1, 4'b1000, 1'b0, 3'd7, 1'b1, 1'b1, 1'b0);

    // Wrong terminal count at 1000: error only with the TC check built, lock kept.
    step(1'b0, 4'b1000, 1'b1, 3'd7, 1'b1, 1'b1, TC_EN);
    step(1'b0, 4'b1000, 1'b0, 3'd7, 1'b1, 1'b1, 1'b0);

    // 300 illegal codes: counter saturates at 255.
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 4'b0101, 1'b0, 3'd7, 1'b0, 1'b0, 1'b1);
    end
    checks++;
    if (m_cnt !== 8'hFF) begin
      errors++;
      $display("FAIL sat_model got %0d want 255", m_cnt);
    end

    // Legal traffic, then asynchronous reset between clock edges.
    repeat (3) begin
      @(negedge clk);
      ce_in   = 1'b0;
      code_in = 4'b1100;
      tc_in   = 1'b0;
    end
    checks++;
    if (err_cnt !== 8'hFF || idx !== 3'd6 || idx_vld !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset idx/vld/cnt got %0d/%0b/%0d want 6/1/255", idx, idx_vld, err_cnt);
    end
    #3;
    clr_n = 1'b0;
    #1;
    chk_zero("async_reset");
    sb.delete();
    m_cnt   = 8'd0;
    ce_in   = 1'b0;
    code_in = 4'b0000;
    @(negedge clk);
    chk_zero("reset_after_edge");
    clr_n = 1'b1;

    step(1'b1, 4'b0000, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'b0001, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'b0011, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0);

    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d pending want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
